// File: rtl/sound_pkg.sv
// Shared types and constants for the sound-path SPI sequencer.
// Frame layouts for the flash READ and the DAC word live here.
package sound_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLASH,
    S_GAP,
    S_DAC,
    S_LOAD
  } state_t;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;
  localparam logic [3:0] DAC_CMD        = 4'b0011;
  localparam logic [5:0] FLASH_BITS     = 6'd48;
  localparam logic [5:0] DAC_BITS       = 6'd16;

  function automatic logic [47:0] flash_frame(
    input logic [23:0] a
  );
    return {FLASH_READ_CMD, a, 16'h0000};
  endfunction

  function automatic logic [47:0] dac_frame(
    input logic [15:0] s
  );
    return {DAC_CMD, s[15:4], 32'h0};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI shifter: SCLK divider, bit counter, 48-bit shift register.
// done is a combinational pulse on the edge that ends the last bit.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [47:0] tx_word,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        done,
  output logic [15:0] rx_word
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic          active;
  logic          half;
  logic [DW-1:0] div;
  logic [5:0]    left;
  logic [47:0]   sh;

  assign done = active & half
              & (div == DIV_MAX)
              & (left == 6'd1);
  assign rx_word = sh[15:0];

  // TX leaves from the top while RX enters at the bottom
  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= 1'b0;
      half   <= 1'b0;
      div    <= '0;
      left   <= '0;
      sh     <= '0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      half   <= 1'b0;
      div    <= '0;
      left   <= nbits;
      sh     <= tx_word;
      sclk   <= 1'b0;
      mosi   <= tx_word[47];
    end else if (active) begin
      if (div != DIV_MAX) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (!half) begin
          half <= 1'b1;
          sclk <= 1'b1;
          sh   <= {sh[46:0], miso};
        end else begin
          half <= 1'b0;
          sclk <= 1'b0;
          if (left == 6'd1) begin
            active <= 1'b0;
            mosi   <= 1'b0;
          end else begin
            left <= left - 1'b1;
            mosi <= sh[47];
          end
        end
      end
    end
  end

endmodule

// File: rtl/sound_spi_sequencer.sv
// Per-sample flash READ then DAC write over a shared SPI bus.
// Define SOUND_LOOP_EN to wrap the playback region instead of stopping.
module sound_spi_sequencer
  import sound_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sound_load,
  input  logic              play,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              spi_miso,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              flash_cs,
  output logic              dac_cs,
  output logic              dac_load,
  output logic [15:0]       sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       fetched;
  logic              gap;
  logic              go;
  logic              start;
  logic [5:0]        nbits;
  logic [47:0]       tx_word;
  logic              shift_done;
  logic [15:0]       rx_word;
  logic [23:0]       a24;
  logic [ADDR_W:0]   next_addr;
  logic              wrap;

  assign a24 = 24'(addr);
  assign go = (state == S_IDLE) & sound_load
            & play & !done;
  assign start = go | ((state == S_GAP) & gap);
  assign nbits = (state == S_GAP) ? DAC_BITS
                                  : FLASH_BITS;
  assign tx_word = (state == S_GAP) ? dac_frame(fetched)
                                    : flash_frame(a24);
  assign next_addr = {1'b0, addr} + (ADDR_W+1)'(2);
  assign wrap = next_addr >= {1'b0, end_addr};

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_eng (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nbits  (nbits),
    .tx_word(tx_word),
    .miso   (spi_miso),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .done   (shift_done),
    .rx_word(rx_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      fetched      <= '0;
      gap          <= 1'b0;
      flash_cs     <= 1'b1;
      dac_cs       <= 1'b1;
      dac_load     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      done         <= 1'b0;
    end else begin
      dac_load     <= 1'b0;
      sample_valid <= 1'b0;
      if (sound_load && state != S_IDLE)
        overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (!play) begin
            addr    <= start_addr;
            overrun <= 1'b0;
            done    <= 1'b0;
          end else if (go) begin
            state    <= S_FLASH;
            flash_cs <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_FLASH: begin
          if (shift_done) begin
            // first byte off the wire is the low byte
            state    <= S_GAP;
            flash_cs <= 1'b1;
            fetched  <= {rx_word[7:0], rx_word[15:8]};
            gap      <= 1'b0;
          end
        end
        S_GAP: begin
          gap <= 1'b1;
          if (gap) begin
            state  <= S_DAC;
            dac_cs <= 1'b0;
          end
        end
        S_DAC: begin
          if (shift_done) begin
            state        <= S_LOAD;
            dac_cs       <= 1'b1;
            dac_load     <= 1'b1;
            sample_valid <= 1'b1;
            sample       <= fetched;
          end
        end
        S_LOAD: begin
          state <= S_IDLE;
          busy  <= 1'b0;
`ifdef SOUND_LOOP_EN
          addr <= wrap ? start_addr
                       : next_addr[ADDR_W-1:0];
`else
          addr <= next_addr[ADDR_W-1:0];
          if (wrap)
            done <= 1'b1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_spi_sequencer.sv
// Directed bench for sound_spi_sequencer with a flash response model.
// Honours SOUND_LOOP_EN for the region-end scenario.
module tb_sound_spi_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sound_load;
  logic        play;
  logic [23:0] start_addr;
  logic [23:0] end_addr;
  logic        spi_miso;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        flash_cs;
  logic        dac_cs;
  logic        dac_load;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int a_bad = 0;
  int sv_cnt = 0;

  sound_spi_sequencer #(
    .CLK_DIV(2),
    .ADDR_W (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sound_load  (sound_load),
    .play        (play),
    .start_addr  (start_addr),
    .end_addr    (end_addr),
    .spi_miso    (spi_miso),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .flash_cs    (flash_cs),
    .dac_cs      (dac_cs),
    .dac_load    (dac_load),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun),
    .done        (done)
  );

  always #5 clk = ~clk;

  // flash model: response bits follow the 32 command/address bits
  logic [15:0] resp;
  logic [47:0] fcap;
  logic [15:0] dcap;
  int          fcnt = 0;

  always @(negedge flash_cs) begin
    fcap = '0;
    fcnt = 0;
  end

  always @(negedge dac_cs) dcap = '0;

  always @(posedge spi_sclk) begin
    if (!flash_cs) begin
      fcap = {fcap[46:0], spi_mosi};
      fcnt = fcnt + 1;
    end
    if (!dac_cs) dcap = {dcap[14:0], spi_mosi};
  end

  always_comb begin
    spi_miso = 1'b0;
    if (fcnt >= 32 && fcnt < 48)
      spi_miso = resp[4'(47 - fcnt)];
  end

  logic p_sclk = 1'b0;
  logic p_mosi = 1'b0;

  always @(negedge clk) begin
    if (sample_valid) sv_cnt++;
    assert (flash_cs || dac_cs) else begin
      $display("FAIL cs_overlap: both CS low");
      a_bad++;
    end
    assert (!(flash_cs && dac_cs && spi_sclk))
    else begin
      $display("FAIL sclk_idle: got 1 need 0");
      a_bad++;
    end
    assert (!(spi_sclk && p_sclk
              && spi_mosi != p_mosi))
    else begin
      $display("FAIL mosi_stable: moved at high");
      a_bad++;
    end
    p_sclk = spi_sclk;
    p_mosi = spi_mosi;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h need %0h",
               nm, act, exp);
    end
  endtask

  int r_load, r_fl0, r_fl1, r_dc0, r_dc1;
  logic r_busy;

  // strobe at cycle 0, then observe cycles 1..span
  task automatic run_txn(input int span,
                         input int ovr_at,
                         input int rst_at);
    @(negedge clk);
    sound_load = 1'b1;
    r_load = -1; r_fl0 = -1; r_fl1 = -1;
    r_dc0 = -1; r_dc1 = -1; r_busy = 1'bx;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      sound_load = (k == ovr_at);
      rst = (k == rst_at) ? 1'b0 : 1'b1;
      if (!flash_cs) begin
        if (r_fl0 < 0) r_fl0 = k;
        r_fl1 = k;
      end
      if (!dac_cs) begin
        if (r_dc0 < 0) r_dc0 = k;
        r_dc1 = k;
      end
      if (r_load > 0 && k == r_load + 1)
        r_busy = busy;
      if (dac_load && r_load < 0) r_load = k;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_flash_cs", flash_cs, 1);
        chk("rst_dac_cs", dac_cs, 1);
        chk("rst_sclk", spi_sclk, 0);
        chk("rst_busy", busy, 0);
      end
    end
    rst = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [23:0] addr;
    logic [15:0] smp;
    logic [15:0] dac;
  } vec_t;

  vec_t vecs[4];
  logic [23:0] reg_addr[4];
  int          reg_fl[4];
  logic        reg_done[4];
  int          sv0;

  initial begin
    vecs[0] = '{8'h34, 8'h12, 24'h100, 16'h1234, 16'h3123};
    vecs[1] = '{8'hCD, 8'hAB, 24'h102, 16'hABCD, 16'h3ABC};
    vecs[2] = '{8'hFF, 8'h00, 24'h104, 16'h00FF, 16'h300F};
    vecs[3] = '{8'h00, 8'h80, 24'h106, 16'h8000, 16'h3800};

    rst = 1'b0;
    play = 1'b0;
    sound_load = 1'b0;
    resp = '0;
    start_addr = 24'h000100;
    end_addr = 24'h000200;
    repeat (3) @(negedge clk);
    chk("reset_flash_cs", flash_cs, 1);
    chk("reset_dac_cs", dac_cs, 1);
    chk("reset_outs",
        {spi_sclk, spi_mosi, dac_load, sample_valid,
         busy, overrun, done, sample},
        0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    play = 1'b1;

    sv0 = sv_cnt;
    for (int i = 0; i < 4; i++) begin
      resp = {vecs[i].lo, vecs[i].hi};
      run_txn(1135, 0, 0);
      chk("flash_cmd_addr", fcap[47:16],
          {8'h03, vecs[i].addr});
      chk("sample", sample, vecs[i].smp);
      chk("dac_word", dcap, vecs[i].dac);
      chk("dac_load_cycle", r_load, 259);
      if (i == 0) begin
        chk("flash_cs_first", r_fl0, 1);
        chk("flash_cs_last", r_fl1, 192);
        chk("dac_cs_first", r_dc0, 195);
        chk("dac_cs_last", r_dc1, 258);
        chk("busy_after_load", r_busy, 0);
      end
    end
    chk("sample_valid_pulses", sv_cnt - sv0, 4);

    // second strobe mid-FLASH
    play = 1'b0;
    repeat (2) @(negedge clk);
    chk("overrun_clear0", overrun, 0);
    play = 1'b1;
    resp = 16'h5AC3;
    run_txn(1135, 50, 0);
    chk("ovr_addr", fcap[47:16], 32'h03000100);
    chk("ovr_load_cycle", r_load, 259);
    chk("ovr_sample", sample, 16'hC35A);
    chk("ovr_dac", dcap, 16'h3C35);
    chk("overrun_set", overrun, 1);
    play = 1'b0;
    repeat (2) @(negedge clk);
    chk("overrun_clear1", overrun, 0);

    // reset mid-FLASH
    play = 1'b1;
    run_txn(400, 0, 120);
    chk("rst_no_load", r_load, -1);
    chk("rst_sample", sample, 0);

    // short region
    play = 1'b0;
    start_addr = 24'h000100;
    end_addr = 24'h000104;
    repeat (2) @(negedge clk);
    play = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resp = 16'h1111;
      run_txn(1135, 0, 0);
      reg_addr[i] = fcap[39:16];
      reg_fl[i] = r_fl0;
      reg_done[i] = done;
    end
    chk("region_addr0", reg_addr[0], 24'h100);
    chk("region_addr1", reg_addr[1], 24'h102);
    chk("region_done0", reg_done[0], 0);
`ifdef SOUND_LOOP_EN
    chk("region_addr2", reg_addr[2], 24'h100);
    chk("region_addr3", reg_addr[3], 24'h102);
    chk("region_done1", reg_done[1], 0);
    chk("region_done3", reg_done[3], 0);
    chk("region_fl3", reg_fl[3], 1);
`else
    chk("region_done1", reg_done[1], 1);
    chk("region_fl2", reg_fl[2], -1);
    chk("region_fl3", reg_fl[3], -1);
    chk("region_no_ovr", overrun, 0);
    play = 1'b0;
    repeat (2) @(negedge clk);
    chk("region_done_clr", done, 0);
`endif

    chk("protocol_assertions", a_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
